// File: rtl/shift_arbiter_pkg.sv
// Shared encodings for the two-requester shift arbiter: operation codes and FSM states.
package shift_arbiter_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ROTL = 2'b00,
        SHL  = 2'b01,
        SRA  = 2'b10,
        SRL  = 2'b11
    } shiftOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } arbState_e;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational 16-bit shifter: rotate-left, shift-left, arithmetic and logical shift-right.
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] dataIn,
    input  logic [CNT_W-1:0]  shiftCnt,
    input  shiftOp_e          shiftOp,
    output logic [DATA_W-1:0] dataOut
);

    logic [2*DATA_W-1:0] rotWide;

    always_comb begin
        // Upper half of the doubled operand shifted left is the rotate result, cnt=0 included.
        rotWide = {dataIn, dataIn} << shiftCnt;
        dataOut = dataIn;
        case (shiftOp)
            ROTL:    dataOut = rotWide[2*DATA_W-1:DATA_W];
            SHL:     dataOut = dataIn << shiftCnt;
            SRA:     dataOut = $signed(dataIn) >>> shiftCnt;
            SRL:     dataOut = dataIn >> shiftCnt;
            default: dataOut = dataIn;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one shifter through an IDLE/CALC/RESP FSM; round-robin or fixed priority.
// Define SHIFT_ARB_STATS_EN to add per-requester grant counters (grant_cnt0/grant_cnt1).
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int FAIR_RR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_vld,
    output logic              req0_rdy,
    input  logic [DATA_W-1:0] req0_in,
    input  logic [CNT_W-1:0]  req0_cnt,
    input  logic [1:0]        req0_op,
    input  logic              req1_vld,
    output logic              req1_rdy,
    input  logic [DATA_W-1:0] req1_in,
    input  logic [CNT_W-1:0]  req1_cnt,
    input  logic [1:0]        req1_op,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    arbState_e         state;
    logic              rrPtr;
    logic [DATA_W-1:0] latIn;
    logic [CNT_W-1:0]  latCnt;
    shiftOp_e          latOp;
    logic              latId;
    logic              anyVld;
    logic              grantId;
    logic              accept;
    logic [DATA_W-1:0] shiftOut;

    always_comb begin
        anyVld   = req0_vld | req1_vld;
        // Requester 1 wins alone, or on a tie when round-robin points at it.
        grantId  = req1_vld & (~req0_vld | ((FAIR_RR != 0) & rrPtr));
        accept   = (state == IDLE) & ~rst & anyVld;
        req0_rdy = accept & ~grantId;
        req1_rdy = accept & grantId;
    end

    shift_arbiter_shifter uShifter (
        .dataIn   (latIn),
        .shiftCnt (latCnt),
        .shiftOp  (latOp),
        .dataOut  (shiftOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rrPtr    <= 1'b0;
            latIn    <= '0;
            latCnt   <= '0;
            latOp    <= ROTL;
            latId    <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyVld) begin
                        latIn  <= grantId ? req1_in  : req0_in;
                        latCnt <= grantId ? req1_cnt : req0_cnt;
                        latOp  <= shiftOp_e'(grantId ? req1_op : req0_op);
                        latId  <= grantId;
                        if (FAIR_RR != 0) rrPtr <= ~grantId;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_data <= shiftOut;
                    rsp_id   <= latId;
                    rsp_vld  <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_vld && req0_rdy) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_vld && req1_rdy) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule
